// File: rtl/prdec_if.sv
// Token handshake between the upstream priority encoder, the decoder and the downstream consumer.
interface prdec_if;
  logic [1:0] code;
  logic       code_v;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out_vec;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output code, code_v, in_valid, out_ready,
    input  in_ready, out_vec, out_valid
  );

  modport slave (
    input  code, code_v, in_valid, out_ready,
    output in_ready, out_vec, out_valid
  );
endinterface

// File: rtl/prdec.sv
// Priority-group decoder with a one-deep output register, per-code statistics and
// a lock-out state entered after three consecutive invalid tokens.
module prdec (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  prdec_if.slave     bus,
  output logic [7:0] cnt3,
  output logic [7:0] cnt2,
  output logic [7:0] cnt1,
  output logic [7:0] cnt0,
  output logic [7:0] err_cnt,
  output logic       err
);
  typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       ready;
  logic       acc_ok, acc_bad;
  logic [5:0] vec_p1;
  logic       vld_p1;
  logic [1:0] consec;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [5:0] decode(input logic [1:0] c);
    logic [5:0] d;
    case (c)
      2'b11:   d = 6'b100000;
      2'b10:   d = 6'b010000;
      2'b01:   d = 6'b000100;
      default: d = 6'b000001;
    endcase
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    err       = 1'b0;
    case (state)
      RUN: begin
        ready = ~vld_p1 | bus.out_ready;
        // The third invalid in a row locks the input; a coincident clr wins.
        if (!clr && bus.in_valid && ready && !bus.code_v && consec == 2'd2)
          state_nxt = ERR;
      end
      ERR: begin
        err = 1'b1;
        if (clr) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign acc_ok  = bus.in_valid & ready & bus.code_v;
  assign acc_bad = bus.in_valid & ready & ~bus.code_v;

  // Output stage: invalid tokens are consumed without touching the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_p1 <= 6'b0;
      vld_p1 <= 1'b0;
    end else if (acc_ok) begin
      vec_p1 <= decode(bus.code);
      vld_p1 <= 1'b1;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_vec   = vec_p1;
  assign bus.out_valid = vld_p1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt3    <= 8'd0;
      cnt2    <= 8'd0;
      cnt1    <= 8'd0;
      cnt0    <= 8'd0;
      err_cnt <= 8'd0;
      consec  <= 2'd0;
    end else if (acc_ok) begin
      case (bus.code)
        2'b11:   cnt3 <= sat_inc(cnt3);
        2'b10:   cnt2 <= sat_inc(cnt2);
        2'b01:   cnt1 <= sat_inc(cnt1);
        default: cnt0 <= sat_inc(cnt0);
      endcase
      consec <= 2'd0;
    end else if (acc_bad) begin
      err_cnt <= sat_inc(err_cnt);
      consec  <= (consec == 2'd3) ? consec : consec + 2'd1;
    end
  end
endmodule

// File: tb/tb_prdec.sv
// Bench for prdec: directed vector table, hand-written corner sequences and a
// randomized run compared every cycle against a behavioural model.
module tb_prdec;
  logic       clk = 1'b0;
  logic       rst, clr;
  logic [7:0] cnt3, cnt2, cnt1, cnt0, err_cnt;
  logic       err;
  logic [7:0] d_cnt[4];

  prdec_if bus();

  prdec dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus),
    .cnt3(cnt3), .cnt2(cnt2), .cnt1(cnt1), .cnt0(cnt0),
    .err_cnt(err_cnt), .err(err)
  );

  always #5 clk = ~clk;

  assign d_cnt[0] = cnt0;
  assign d_cnt[1] = cnt1;
  assign d_cnt[2] = cnt2;
  assign d_cnt[3] = cnt3;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [5:0] m_vec;
  bit         m_vld, m_err;
  int         m_cnt[4];
  int         m_err_cnt, m_consec;
  logic       last_rdy;
  logic [5:0] dec_tab[4] = '{6'b000001, 6'b000100, 6'b010000, 6'b100000};

  typedef struct {
    bit         iv;
    logic [1:0] code;
    bit         cv;
    bit         ordy;
    bit         exp_rdy;
    logic [5:0] exp_vec;
    bit         exp_vld;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_rdy(input bit ordy);
    return !m_err && (!m_vld || ordy);
  endfunction

  task automatic model_reset();
    m_vec = 6'b0; m_vld = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err_cnt = 0; m_consec = 0;
  endtask

  task automatic model_step(input bit iv, input logic [1:0] code, input bit cv,
                            input bit ordy, input bit c, input bit r);
    bit acc;
    acc = iv && m_rdy(ordy);
    if (r) begin
      model_reset();
    end else begin
      if (acc && cv) begin
        m_vec = dec_tab[code];
        m_vld = 1;
      end else if (m_vld && ordy) begin
        m_vld = 0;
      end
      if (c) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_err_cnt = 0; m_consec = 0; m_err = 0;
      end else if (acc) begin
        if (cv) begin
          if (m_cnt[code] < 255) m_cnt[code]++;
          m_consec = 0;
        end else begin
          if (m_err_cnt < 255) m_err_cnt++;
          m_consec++;
          if (m_consec >= 3) m_err = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy(bus.out_ready)));
    chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
    chk("out_vec", 32'(bus.out_vec), 32'(m_vec));
    chk("err", 32'(err), 32'(m_err));
    for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
    chk("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
  endtask

  // One clock: drive, check against the model before the edge, advance the model.
  task automatic apply(input bit iv, input logic [1:0] code, input bit cv,
                       input bit ordy, input bit c, input bit r);
    bus.in_valid = iv; bus.code = code; bus.code_v = cv; bus.out_ready = ordy;
    clr = c; rst = r;
    @(negedge clk);
    last_rdy = bus.in_ready;
    check_all();
    model_step(iv, code, cv, ordy, c, r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 2'd3, 1, 1, 1, 6'b100000, 1};
    tbl[1]  = '{1, 2'd2, 1, 1, 1, 6'b010000, 1};
    tbl[2]  = '{1, 2'd1, 1, 1, 1, 6'b000100, 1};
    tbl[3]  = '{1, 2'd0, 1, 1, 1, 6'b000001, 1};
    tbl[4]  = '{0, 2'd0, 0, 1, 1, 6'b000001, 0};
    tbl[5]  = '{1, 2'd1, 1, 0, 1, 6'b000100, 1};
    tbl[6]  = '{1, 2'd3, 1, 0, 0, 6'b000100, 1};
    tbl[7]  = '{1, 2'd3, 1, 1, 1, 6'b100000, 1};
    tbl[8]  = '{0, 2'd0, 0, 1, 1, 6'b100000, 0};
    tbl[9]  = '{1, 2'd2, 0, 1, 1, 6'b100000, 0};
    tbl[10] = '{1, 2'd1, 0, 1, 1, 6'b100000, 0};
    tbl[11] = '{1, 2'd0, 0, 1, 1, 6'b100000, 0};
    tbl[12] = '{1, 2'd0, 1, 1, 0, 6'b100000, 0};

    // Reset with a token presented; it must be discarded.
    bus.in_valid = 1; bus.code = 2'd3; bus.code_v = 1; bus.out_ready = 0;
    clr = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_vec", 32'(bus.out_vec), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnt", {cnt3, cnt2, cnt1, cnt0}, 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Decode sweep, backpressure and error lock
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].iv, tbl[i].code, tbl[i].cv, tbl[i].ordy, 0, 0);
      chk($sformatf("tbl%0d_rdy", i), 32'(last_rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_vec", i), 32'(bus.out_vec), 32'(tbl[i].exp_vec));
      chk($sformatf("tbl%0d_vld", i), 32'(bus.out_valid), 32'(tbl[i].exp_vld));
      if (i == 4) chk("sweep_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h01010101);
    end
    chk("lock_err", 32'(err), 32'd1);
    chk("lock_err_cnt", 32'(err_cnt), 32'd3);
    chk("lock_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h02010201);

    apply(0, 2'd0, 0, 1, 1, 0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);

    // A valid token in the middle restarts the consecutive-invalid run
    apply(1, 2'd2, 0, 1, 0, 0);
    apply(1, 2'd2, 0, 1, 0, 0);
    apply(1, 2'd0, 1, 1, 0, 0);
    apply(1, 2'd1, 0, 1, 0, 0);
    chk("consec_err", 32'(err), 32'd0);
    chk("consec_err_cnt", 32'(err_cnt), 32'd3);
    chk("consec_cnt0", 32'(cnt0), 32'd1);

    for (int i = 0; i < 300; i++) apply(1, 2'd2, 1, 1, 0, 0);
    chk("sat_cnt2", 32'(cnt2), 32'd255);

    // clr colliding with an accepted token: decoded but not counted
    apply(1, 2'd0, 1, 1, 1, 0);
    chk("coll_vec", 32'(bus.out_vec), 32'b000001);
    chk("coll_vld", 32'(bus.out_valid), 32'd1);
    chk("coll_cnt0", 32'(cnt0), 32'd0);
    chk("coll_cnt2", 32'(cnt2), 32'd0);

    // Reset mid-operation with a pending output and a presented token
    apply(1, 2'd3, 1, 1, 0, 0);
    chk("pre_rst_vld", 32'(bus.out_valid), 32'd1);
    apply(1, 2'd1, 1, 0, 0, 1);
    chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_vec", 32'(bus.out_vec), 32'd0);
    chk("mid_rst_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 2000; i++) begin
      apply($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
    end
    apply(0, 2'd0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
